// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with glitch-free ratio changes, per-channel
// rising-edge tick strobes and a common phase-align restart.
// Latency: outputs are registered; a write shows on pending next cycle, and the new
// ratio takes effect from the next period boundary.
// Backpressure: none; writes are always accepted or rejected in one cycle (div_err).
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   enable              global count enable; low freezes every channel (tick forced 0)
//   sync_restart        one-cycle pulse restarting all channels at the start of a high phase
//   div_wr/div_ch/div_val  ratio write strobe, target channel, requested ratio N
//   div_err             one-cycle pulse for a rejected write (N<2 or channel out of range)
//   pending             per channel: a new ratio is waiting for the period boundary
//   div_clk_out         per channel divided clock, high for ceil(N/2) of every N cycles
//   tick                per channel pulse coincident with each rising edge of div_clk_out
module clk_div_prog #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sync_restart,
  input  logic                div_wr,
  input  logic [CH_W-1:0]     div_ch,
  input  logic [DIV_W-1:0]    div_val,
  output logic                div_err,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] div_clk_out,
  output logic [CHANNELS-1:0] tick
);

  // Lookup of which encodable channel indices actually exist; avoids a range compare
  // that would be constant when CHANNELS is a power of two.
  function automatic logic [(2**CH_W)-1:0] ch_mask_f();
    logic [(2**CH_W)-1:0] m;
    for (int i = 0; i < 2**CH_W; i++) begin
      m[i] = (i < CHANNELS);
    end
    return m;
  endfunction

  localparam logic [(2**CH_W)-1:0] CH_MASK = ch_mask_f();

  // Length of the high phase: ceil(N/2), computed one bit wider so N=2^DIV_W-1 cannot overflow.
  function automatic logic [DIV_W-1:0] half_f(input logic [DIV_W-1:0] n);
    logic [DIV_W:0] t;
    t = {1'b0, n} + (DIV_W+1)'(1);
    return t[DIV_W:1];
  endfunction

  logic [CHANNELS-1:0][DIV_W-1:0] n_q, n_d;      // active ratio
  logic [CHANNELS-1:0][DIV_W-1:0] s_q, s_d;      // shadow ratio awaiting a boundary
  logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;  // position within the current period
  logic [CHANNELS-1:0]            p_q, p_d;
  logic [CHANNELS-1:0]            out_q, out_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;
  logic                           div_err_q, div_err_d;
  logic                           wr_ok;
  logic                           wrap;

  always_comb begin
    n_d       = n_q;
    s_d       = s_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    tick_d    = '0;
    wrap      = 1'b0;
    wr_ok     = div_wr && (div_val >= DIV_W'(2)) && CH_MASK[div_ch];
    div_err_d = div_wr && !wr_ok;

    for (int i = 0; i < CHANNELS; i++) begin
      if (sync_restart) begin
        // Restart consumes only a ratio that was already pending before this edge.
        if (p_q[i]) begin
          n_d[i] = s_q[i];
          p_d[i] = 1'b0;
        end
        cnt_d[i]  = '0;
        out_d[i]  = 1'b1;
        tick_d[i] = 1'b1;
      end else if (enable) begin
        // Boundary test uses the old ratio; the new one governs from cnt=0.
        wrap = (cnt_q[i] == n_q[i] - DIV_W'(1));
        if (wrap) begin
          cnt_d[i] = '0;
          if (p_q[i]) begin
            n_d[i] = s_q[i];
            p_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        out_d[i]  = (cnt_d[i] < half_f(n_d[i]));
        tick_d[i] = wrap;
      end

      // Applied after the boundary logic so a same-edge write waits for the next wrap.
      if (wr_ok && (div_ch == CH_W'(i))) begin
        s_d[i] = div_val;
        p_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q       <= {CHANNELS{DIV_W'(DEFAULT_DIV)}};
      s_q       <= {CHANNELS{DIV_W'(DEFAULT_DIV)}};
      cnt_q     <= {CHANNELS{DIV_W'(DEFAULT_DIV - 1)}};
      p_q       <= '0;
      out_q     <= '0;
      tick_q    <= '0;
      div_err_q <= 1'b0;
    end else begin
      n_q       <= n_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      div_err_q <= div_err_d;
    end
  end

  assign div_err     = div_err_q;
  assign pending     = p_q;
  assign div_clk_out = out_q;
  assign tick        = tick_q;

endmodule
